// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its opcode decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_t;

  localparam logic [3:0] OP_LOAD  = 4'd7;
  localparam logic [3:0] OP_STORE = 4'd8;
  localparam logic [3:0] OP_BEQ   = 4'd11;

  localparam logic [1:0] IMM_NONE = 2'b11;
  localparam logic [1:0] IMM_I    = 2'b01;
  localparam logic [1:0] IMM_S    = 2'b00;
  localparam logic [1:0] IMM_B    = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/data handshake inputs and datapath control outputs of the control unit.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int IMMSRC_W = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic                instr_valid;
  logic                zero;
  logic                mem_ready;
  logic                ir_write;
  logic                pc_write;
  logic                pc_src;
  logic                result_src;
  logic                mem_read;
  logic                mem_write;
  logic                alu_src;
  logic [IMMSRC_W-1:0] imm_src;
  logic                reg_write;
  logic                retire;
  logic                fault;
  logic [2:0]          state_o;

  modport master (
    output opcode, instr_valid, zero, mem_ready,
    input  ir_write, pc_write, pc_src, result_src, mem_read, mem_write,
           alu_src, imm_src, reg_write, retire, fault, state_o
  );

  modport slave (
    input  opcode, instr_valid, zero, mem_ready,
    output ir_write, pc_write, pc_src, result_src, mem_read, mem_write,
           alu_src, imm_src, reg_write, retire, fault, state_o
  );
endinterface

// File: rtl/opcode_class_decoder.sv
// Combinational map from latched opcode to instruction class and static datapath selects.
module opcode_class_decoder
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int IMMSRC_W = 2
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output op_class_t           o_class,
  output logic                o_alu_src,
  output logic [IMMSRC_W-1:0] o_imm_src,
  output logic                o_result_src,
  output logic                o_illegal
);

  logic       w_upper_set;
  logic [3:0] w_low;
  logic [1:0] w_imm;

  assign w_low = i_opcode[3:0];

  // Any bit above the decoded nibble makes the opcode illegal.
  if (OPCODE_W > 4) begin : g_upper
    assign w_upper_set = |i_opcode[OPCODE_W-1:4];
  end else begin : g_no_upper
    assign w_upper_set = 1'b0;
  end

  always_comb begin
    o_class      = CLS_ILLEGAL;
    o_alu_src    = 1'b0;
    w_imm        = IMM_NONE;
    o_result_src = 1'b0;
    if (!w_upper_set) begin
      case (w_low)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          o_class = CLS_ALU;
        end
        4'd6: begin
          o_class   = CLS_ALU;
          o_alu_src = 1'b1;
          w_imm     = IMM_B;
        end
        OP_LOAD: begin
          o_class      = CLS_LOAD;
          o_alu_src    = 1'b1;
          w_imm        = IMM_I;
          o_result_src = 1'b1;
        end
        OP_STORE: begin
          o_class   = CLS_STORE;
          o_alu_src = 1'b1;
          w_imm     = IMM_I;
        end
        4'd9: begin
          o_class   = CLS_ALU;
          o_alu_src = 1'b1;
          w_imm     = IMM_I;
        end
        4'd10: begin
          o_class   = CLS_ALU;
          o_alu_src = 1'b1;
          w_imm     = IMM_S;
        end
        OP_BEQ: begin
          o_class = CLS_BRANCH;
        end
        default: begin
          o_class = CLS_ILLEGAL;
        end
      endcase
    end
  end

  assign o_imm_src = IMMSRC_W'(w_imm);
  assign o_illegal = (o_class == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with memory stalls and a sticky fault.
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int IMMSRC_W    = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                      clk,
  input logic                      rst,
  multicycle_control_unit_if.slave ctrl_if
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_TIMEOUT < 1) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [CNT_W-1:0]    r_wait_cnt;

  op_class_t           w_class;
  logic                w_dec_alu_src;
  logic [IMMSRC_W-1:0] w_dec_imm_src;
  logic                w_dec_result_src;
  logic                w_dec_illegal;
  logic                w_timeout_hit;

  logic                w_ir_write;
  logic                w_pc_write;
  logic                w_pc_src;
  logic                w_result_src;
  logic                w_mem_read;
  logic                w_mem_write;
  logic                w_alu_src;
  logic [IMMSRC_W-1:0] w_imm_src;
  logic                w_reg_write;
  logic                w_retire;
  logic                w_fault;

  opcode_class_decoder #(
    .OPCODE_W (OPCODE_W),
    .IMMSRC_W (IMMSRC_W)
  ) u_decoder (
    .i_opcode     (r_opcode),
    .o_class      (w_class),
    .o_alu_src    (w_dec_alu_src),
    .o_imm_src    (w_dec_imm_src),
    .o_result_src (w_dec_result_src),
    .o_illegal    (w_dec_illegal)
  );

  // The last permitted wait cycle is the one where the counter holds MEM_TIMEOUT-1.
  assign w_timeout_hit = (MEM_TIMEOUT != 0) && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_opcode   <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_FETCH && ctrl_if.instr_valid) begin
        r_opcode <= ctrl_if.opcode;
      end
      if (r_state != ST_MEM) begin
        r_wait_cnt <= '0;
      end else if (!ctrl_if.mem_ready) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_result_src = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_imm_src    = IMMSRC_W'(IMM_NONE);
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_fault      = 1'b0;

    case (r_state)
      ST_FETCH: begin
        w_ir_write = ctrl_if.instr_valid;
        if (ctrl_if.instr_valid) begin
          w_state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        w_state_next = w_dec_illegal ? ST_FAULT : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        w_alu_src = w_dec_alu_src;
        w_imm_src = w_dec_imm_src;
        case (w_class)
          CLS_ALU:   w_state_next = ST_WRITEBACK;
          CLS_LOAD,
          CLS_STORE: w_state_next = ST_MEM;
          CLS_BRANCH: begin
            w_pc_write   = 1'b1;
            w_retire     = 1'b1;
            w_pc_src     = ctrl_if.zero;
            w_state_next = ST_FETCH;
          end
          default:   w_state_next = ST_FAULT;
        endcase
      end

      ST_MEM: begin
        w_alu_src   = w_dec_alu_src;
        w_imm_src   = w_dec_imm_src;
        w_mem_read  = (w_class == CLS_LOAD);
        w_mem_write = (w_class == CLS_STORE);
        // A ready on the final permitted cycle completes the access instead of faulting.
        if (ctrl_if.mem_ready) begin
          if (w_class == CLS_LOAD) begin
            w_state_next = ST_WRITEBACK;
          end else begin
            w_pc_write   = 1'b1;
            w_retire     = 1'b1;
            w_state_next = ST_FETCH;
          end
        end else if (w_timeout_hit) begin
          w_state_next = ST_FAULT;
        end
      end

      ST_WRITEBACK: begin
        w_alu_src    = w_dec_alu_src;
        w_imm_src    = w_dec_imm_src;
        w_result_src = w_dec_result_src;
        w_reg_write  = 1'b1;
        w_pc_write   = 1'b1;
        w_retire     = 1'b1;
        w_state_next = ST_FETCH;
      end

      ST_FAULT: begin
        w_fault = 1'b1;
      end

      default: begin
        w_state_next = ST_FAULT;
      end
    endcase
  end

  assign ctrl_if.ir_write   = w_ir_write;
  assign ctrl_if.pc_write   = w_pc_write;
  assign ctrl_if.pc_src     = w_pc_src;
  assign ctrl_if.result_src = w_result_src;
  assign ctrl_if.mem_read   = w_mem_read;
  assign ctrl_if.mem_write  = w_mem_write;
  assign ctrl_if.alu_src    = w_alu_src;
  assign ctrl_if.imm_src    = w_imm_src;
  assign ctrl_if.reg_write  = w_reg_write;
  assign ctrl_if.retire     = w_retire;
  assign ctrl_if.fault      = w_fault;
  assign ctrl_if.state_o    = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed, table-driven bench for the multi-cycle control unit.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       result_src;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       retire;
    logic       fault;
    logic [2:0] state;
  } out_t;

  typedef struct {
    logic       rst;
    logic [3:0] op;
    logic       iv;
    logic       z;
    logic       mr;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  vec_t vecs[$];

  multicycle_control_unit_if #(.OPCODE_W(4), .IMMSRC_W(2)) bus ();

  multicycle_control_unit #(
    .OPCODE_W    (4),
    .IMMSRC_W    (2),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  always #5 clk = ~clk;

  // Flags: I=ir_write P=pc_write S=pc_src R=result_src L=mem_read W=mem_write
  //        A=alu_src G=reg_write T=retire F=fault
  function automatic out_t mk(input string fl, input logic [1:0] imm, input logic [2:0] st);
    out_t o;
    o = '0;
    o.imm_src = imm;
    o.state   = st;
    for (int i = 0; i < fl.len(); i++) begin
      case (fl[i])
        "I": o.ir_write   = 1'b1;
        "P": o.pc_write   = 1'b1;
        "S": o.pc_src     = 1'b1;
        "R": o.result_src = 1'b1;
        "L": o.mem_read   = 1'b1;
        "W": o.mem_write  = 1'b1;
        "A": o.alu_src    = 1'b1;
        "G": o.reg_write  = 1'b1;
        "T": o.retire     = 1'b1;
        "F": o.fault      = 1'b1;
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic add(input logic r, input logic [3:0] op, input logic iv, input logic z,
                     input logic mr, input string fl, input logic [1:0] imm, input logic [2:0] st);
    vec_t v;
    v.rst = r; v.op = op; v.iv = iv; v.z = z; v.mr = mr;
    v.exp = mk(fl, imm, st);
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] op, input logic iv, input logic z,
                      input logic mr, input out_t exp, input string name);
    out_t got;
    @(negedge clk);
    rst             = r;
    bus.opcode      = op;
    bus.instr_valid = iv;
    bus.zero        = z;
    bus.mem_ready   = mr;
    #1;
    cyc++;
    got = {bus.ir_write, bus.pc_write, bus.pc_src, bus.result_src, bus.mem_read,
           bus.mem_write, bus.alu_src, bus.imm_src, bus.reg_write, bus.retire,
           bus.fault, bus.state_o};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, exp);
    end else begin
      $display("ok   %s cyc=%0d outputs=%b", name, cyc, got);
    end
    n_cmp++;
    if ((bus.mem_read && bus.mem_write) || (bus.retire !== bus.pc_write) ||
        (bus.reg_write && bus.state_o != 3'd4)) begin
      n_err++;
      $display("FAIL invariant_%s cyc=%0d got rd=%b wr=%b ret=%b pcw=%b rw=%b st=%0d required consistent",
               name, cyc, bus.mem_read, bus.mem_write, bus.retire, bus.pc_write,
               bus.reg_write, bus.state_o);
    end
  endtask

  initial begin
    bus.opcode      = '0;
    bus.instr_valid = 1'b0;
    bus.zero        = 1'b0;
    bus.mem_ready   = 1'b0;
    repeat (2) @(posedge clk);

    // rst, op, iv, z, mr, flags, imm, state
    add(0, 4'd0,  0, 0, 0, "",      2'b11, 3'd0);  // reset state
    // R-type opcode 3
    add(0, 4'd3,  1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd13, 0, 0, 0, "",      2'b11, 3'd1);
    add(0, 4'd13, 0, 0, 0, "",      2'b11, 3'd2);
    add(0, 4'd13, 0, 0, 0, "PGT",   2'b11, 3'd4);
    add(0, 4'd6,  0, 0, 0, "",      2'b11, 3'd0);  // instr_valid stall
    // I-ALU opcode 6
    add(0, 4'd6,  1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd12, 0, 0, 0, "",      2'b11, 3'd1);
    add(0, 4'd12, 0, 0, 0, "A",     2'b10, 3'd2);
    add(0, 4'd12, 0, 0, 0, "APGT",  2'b10, 3'd4);
    // load with two wait states
    add(0, 4'd7,  1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd13, 0, 0, 0, "",      2'b11, 3'd1);
    add(0, 4'd13, 0, 0, 0, "A",     2'b01, 3'd2);
    add(0, 4'd13, 0, 0, 0, "AL",    2'b01, 3'd3);
    add(0, 4'd13, 0, 0, 0, "AL",    2'b01, 3'd3);
    add(0, 4'd13, 0, 0, 1, "AL",    2'b01, 3'd3);
    add(0, 4'd13, 0, 0, 0, "ARPGT", 2'b01, 3'd4);
    // store, no wait
    add(0, 4'd8,  1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd0,  0, 0, 0, "",      2'b11, 3'd1);
    add(0, 4'd0,  0, 0, 0, "A",     2'b01, 3'd2);
    add(0, 4'd0,  0, 0, 1, "AWPT",  2'b01, 3'd3);
    // branch taken / not taken
    add(0, 4'd11, 1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd0,  0, 0, 0, "",      2'b11, 3'd1);
    add(0, 4'd0,  0, 1, 0, "PST",   2'b11, 3'd2);
    add(0, 4'd11, 1, 1, 0, "I",     2'b11, 3'd0);
    add(0, 4'd0,  0, 1, 0, "",      2'b11, 3'd1);
    add(0, 4'd0,  0, 0, 0, "PT",    2'b11, 3'd2);
    // I-ALU opcodes 10 and 9
    add(0, 4'd10, 1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd0,  0, 0, 0, "",      2'b11, 3'd1);
    add(0, 4'd0,  0, 0, 0, "A",     2'b00, 3'd2);
    add(0, 4'd0,  0, 0, 0, "APGT",  2'b00, 3'd4);
    add(0, 4'd9,  1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd0,  0, 0, 0, "",      2'b11, 3'd1);
    add(0, 4'd0,  0, 0, 0, "A",     2'b01, 3'd2);
    add(0, 4'd0,  0, 0, 0, "APGT",  2'b01, 3'd4);
    // illegal 12, then reset out of FAULT
    add(0, 4'd12, 1, 0, 0, "I",     2'b11, 3'd0);
    add(0, 4'd3,  1, 1, 1, "",      2'b11, 3'd1);
    add(0, 4'd3,  1, 1, 1, "F",     2'b11, 3'd5);
    add(1, 4'd3,  0, 0, 0, "F",     2'b11, 3'd5);
    add(0, 4'd0,  0, 0, 0, "",      2'b11, 3'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].iv, vecs[i].z, vecs[i].mr, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // Illegal 13: fault sticky for 20 cycles under arbitrary inputs, then reset.
    step(0, 4'd13, 1, 0, 0, mk("I", 2'b11, 3'd0), "ill_fetch");
    step(0, 4'd0,  0, 0, 0, mk("",  2'b11, 3'd1), "ill_decode");
    for (int i = 0; i < 20; i++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 15));
      step(0, rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), mk("F", 2'b11, 3'd5), "fault_sticky");
    end
    step(1, 4'd0, 0, 0, 0, mk("F", 2'b11, 3'd5), "fault_rst");
    step(0, 4'd0, 0, 0, 0, mk("",  2'b11, 3'd0), "fault_cleared");

    // Store timeout: 15 mem_write cycles then FAULT.
    step(0, 4'd8, 1, 0, 0, mk("I", 2'b11, 3'd0), "to_fetch");
    step(0, 4'd0, 0, 0, 0, mk("",  2'b11, 3'd1), "to_decode");
    step(0, 4'd0, 0, 0, 0, mk("A", 2'b01, 3'd2), "to_exec");
    for (int i = 0; i < 15; i++) begin
      step(0, 4'd0, 0, 0, 0, mk("AW", 2'b01, 3'd3), "to_wait");
    end
    step(0, 4'd0, 0, 0, 1, mk("F", 2'b11, 3'd5), "to_fault");
    step(1, 4'd0, 0, 0, 0, mk("F", 2'b11, 3'd5), "to_rst");

    // Store with ready on the 15th wait cycle: completes, no fault.
    step(0, 4'd8, 1, 0, 0, mk("I", 2'b11, 3'd0), "edge_fetch");
    step(0, 4'd0, 0, 0, 0, mk("",  2'b11, 3'd1), "edge_decode");
    step(0, 4'd0, 0, 0, 0, mk("A", 2'b01, 3'd2), "edge_exec");
    for (int i = 0; i < 14; i++) begin
      step(0, 4'd0, 0, 0, 0, mk("AW", 2'b01, 3'd3), "edge_wait");
    end
    step(0, 4'd0, 0, 0, 1, mk("AWPT", 2'b01, 3'd3), "edge_ready");
    step(0, 4'd0, 0, 0, 0, mk("",     2'b11, 3'd0), "edge_fetch_again");

    // Reset during a load wait: back to FETCH, no register write afterwards.
    step(0, 4'd7, 1, 0, 0, mk("I",  2'b11, 3'd0), "rm_fetch");
    step(0, 4'd0, 0, 0, 0, mk("",   2'b11, 3'd1), "rm_decode");
    step(0, 4'd0, 0, 0, 0, mk("A",  2'b01, 3'd2), "rm_exec");
    step(0, 4'd0, 0, 0, 0, mk("AL", 2'b01, 3'd3), "rm_wait");
    step(1, 4'd0, 0, 0, 1, mk("AL", 2'b01, 3'd3), "rm_rst");
    for (int i = 0; i < 4; i++) begin
      step(0, 4'd7, 0, 0, 1, mk("", 2'b11, 3'd0), "rm_after");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
